// File: rtl/ring_buffer_pkg.sv
// Shared defaults and sizing helper for the ring buffer FIFO.
package ring_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_BITS  = 2;

    function automatic int depth(input int addr_bits);
        return 2 ** addr_bits;
    endfunction

endpackage

// File: rtl/ring_buffer_if.sv
// Producer/consumer bus of the ring buffer; the buffer itself is the slave side.
interface ring_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  writeEnable;
    logic [DATA_WIDTH-1:0] data;
    logic                  readEnable;
    logic                  dataReadAck;
    logic [DATA_WIDTH-1:0] dataRead;
    logic [31:0]           bufferLength;
    logic [31:0]           debug;
    logic [31:0]           debug2;

    modport master (
        output writeEnable, data, readEnable,
        input  dataReadAck, dataRead, bufferLength, debug, debug2
    );

    modport slave (
        input  writeEnable, data, readEnable,
        output dataReadAck, dataRead, bufferLength, debug, debug2
    );
endinterface

// File: rtl/ring_buffer_mem.sv
// Register-array storage with one write port and one registered read port.
module ring_buffer_mem
    import ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = depth(ADDR_BITS);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Read samples the pre-write contents, so a full read+write to one slot returns the old entry.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = re ? mem_q[raddr] : rdata_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ring_buffer.sv
// Single-clock FIFO ring buffer: pointers, occupancy and accept logic around ring_buffer_mem.
module ring_buffer
    import ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input  logic         clk,
    input  logic         reset,
    ring_buffer_if.slave bus
);
    localparam int                 DEPTH      = depth(ADDR_BITS);
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    logic [ADDR_BITS-1:0]  head_q, head_d;
    logic [ADDR_BITS-1:0]  tail_q, tail_d;
    logic [ADDR_BITS:0]    count_q, count_d;
    logic                  ack_q, ack_d;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] rd_data;

    // Full/empty come from the occupancy count; a read in the same cycle frees room for a write.
    always_comb begin
        rd_accept = bus.readEnable && (count_q != '0);
        wr_accept = bus.writeEnable && ((count_q != FULL_COUNT) || rd_accept);
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ack_d     = rd_accept;
        if (wr_accept) begin
            head_d = head_q + 1'b1;
        end
        if (rd_accept) begin
            tail_d = tail_q + 1'b1;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ack_q   <= ack_d;
        end
    end

    // Storage must not change while reset holds off the requests.
    assign mem_we = wr_accept && reset;
    assign mem_re = rd_accept && reset;

    ring_buffer_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (head_q),
        .wdata (bus.data),
        .re    (mem_re),
        .raddr (tail_q),
        .rdata (rd_data)
    );

    assign bus.dataReadAck  = ack_q;
    assign bus.dataRead     = rd_data;
    assign bus.bufferLength = 32'(count_q);
    assign bus.debug        = 32'(head_q);
    assign bus.debug2       = 32'(tail_q);

endmodule

// File: tb/tb_ring_buffer.sv
// Directed bench for ring_buffer (DEPTH = 4, 8-bit entries).
module tb_ring_buffer;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ring_buffer_if #(.DATA_WIDTH(8)) bus ();

    ring_buffer #(
        .DATA_WIDTH(8),
        .ADDR_BITS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Apply one cycle of requests and settle just after the rising edge.
    task automatic cyc(input logic we, input logic [7:0] d, input logic re);
        bus.writeEnable = we;
        bus.data        = d;
        bus.readEnable  = re;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        n_cmp++; if (bus.bufferLength !== 32'd0) begin n_bad++; $display("FAIL reset_len: got %0d want 0", bus.bufferLength); end
        n_cmp++; if (bus.debug !== 32'd0) begin n_bad++; $display("FAIL reset_head: got %0d want 0", bus.debug); end
        n_cmp++; if (bus.debug2 !== 32'd0) begin n_bad++; $display("FAIL reset_tail: got %0d want 0", bus.debug2); end
        n_cmp++; if (bus.dataReadAck !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.dataReadAck); end
        n_cmp++; if (bus.dataRead !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.dataRead); end
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_fill_drain();
        int wv [3] = '{1, 2, 3};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'(wv[i]), 1'b0);
            n_cmp++; if (bus.bufferLength !== 32'(i + 1)) begin n_bad++; $display("FAIL fill_len[%0d]: got %0d want %0d", i, bus.bufferLength, i + 1); end
        end
        n_cmp++; if (bus.debug !== 32'd3) begin n_bad++; $display("FAIL fill_head: got %0d want 3", bus.debug); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            n_cmp++; if (bus.dataReadAck !== 1'b1) begin n_bad++; $display("FAIL drain_ack[%0d]: got %b want 1", i, bus.dataReadAck); end
            n_cmp++; if (bus.dataRead !== 8'(wv[i])) begin n_bad++; $display("FAIL drain_data[%0d]: got %0d want %0d", i, bus.dataRead, wv[i]); end
            n_cmp++; if (bus.bufferLength !== 32'(2 - i)) begin n_bad++; $display("FAIL drain_len[%0d]: got %0d want %0d", i, bus.bufferLength, 2 - i); end
        end
        cyc(1'b0, 8'h00, 1'b0);
        n_cmp++; if (bus.dataReadAck !== 1'b0) begin n_bad++; $display("FAIL ack_pulse: got %b want 0", bus.dataReadAck); end
        n_cmp++; if (bus.debug2 !== 32'd2) begin n_bad++; $display("FAIL drain_tail: got %0d want 2", bus.debug2); end
    endtask

    task automatic test_full_wrap();
        int wv [3] = '{6, 7, 8};
        int rv [4] = '{3, 6, 7, 8};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'(wv[i]), 1'b0);
            n_cmp++; if (bus.bufferLength !== 32'(i + 2)) begin n_bad++; $display("FAIL wrap_len[%0d]: got %0d want %0d", i, bus.bufferLength, i + 2); end
        end
        // head started at 3; three more writes wrap it to 2
        n_cmp++; if (bus.debug !== 32'd2) begin n_bad++; $display("FAIL wrap_head: got %0d want 2", bus.debug); end
        cyc(1'b1, 8'd9, 1'b0);
        n_cmp++; if (bus.bufferLength !== 32'd4) begin n_bad++; $display("FAIL full_drop_len: got %0d want 4", bus.bufferLength); end
        n_cmp++; if (bus.debug !== 32'd2) begin n_bad++; $display("FAIL full_drop_head: got %0d want 2", bus.debug); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            n_cmp++; if (bus.dataReadAck !== 1'b1) begin n_bad++; $display("FAIL wrap_ack[%0d]: got %b want 1", i, bus.dataReadAck); end
            n_cmp++; if (bus.dataRead !== 8'(rv[i])) begin n_bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, bus.dataRead, rv[i]); end
            n_cmp++; if (bus.bufferLength !== 32'(3 - i)) begin n_bad++; $display("FAIL wrap_rlen[%0d]: got %0d want %0d", i, bus.bufferLength, 3 - i); end
        end
        n_cmp++; if (bus.debug2 !== 32'd2) begin n_bad++; $display("FAIL wrap_tail: got %0d want 2", bus.debug2); end
    endtask

    task automatic test_empty_read();
        cyc(1'b0, 8'h00, 1'b1);
        n_cmp++; if (bus.dataReadAck !== 1'b0) begin n_bad++; $display("FAIL empty_ack: got %b want 0", bus.dataReadAck); end
        n_cmp++; if (bus.bufferLength !== 32'd0) begin n_bad++; $display("FAIL empty_len: got %0d want 0", bus.bufferLength); end
        n_cmp++; if (bus.debug2 !== 32'd2) begin n_bad++; $display("FAIL empty_tail: got %0d want 2", bus.debug2); end
        n_cmp++; if (bus.debug !== 32'd2) begin n_bad++; $display("FAIL empty_head: got %0d want 2", bus.debug); end
        n_cmp++; if (bus.dataRead !== 8'd8) begin n_bad++; $display("FAIL empty_hold: got %0d want 8", bus.dataRead); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] rv [4] = '{8'h12, 8'h13, 8'h14, 8'hAA};
        cyc(1'b1, 8'h10, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h12, 1'b1);
        n_cmp++; if (bus.dataReadAck !== 1'b1 || bus.dataRead !== 8'h10) begin n_bad++; $display("FAIL rw_mid_data: got ack=%b data=%h want ack=1 data=10", bus.dataReadAck, bus.dataRead); end
        n_cmp++; if (bus.bufferLength !== 32'd2) begin n_bad++; $display("FAIL rw_mid_len: got %0d want 2", bus.bufferLength); end
        cyc(1'b1, 8'h13, 1'b0);
        cyc(1'b1, 8'h14, 1'b0);
        n_cmp++; if (bus.bufferLength !== 32'd4) begin n_bad++; $display("FAIL rw_fill_len: got %0d want 4", bus.bufferLength); end
        cyc(1'b1, 8'hAA, 1'b1);
        n_cmp++; if (bus.dataReadAck !== 1'b1 || bus.dataRead !== 8'h11) begin n_bad++; $display("FAIL rw_full_data: got ack=%b data=%h want ack=1 data=11", bus.dataReadAck, bus.dataRead); end
        n_cmp++; if (bus.bufferLength !== 32'd4) begin n_bad++; $display("FAIL rw_full_len: got %0d want 4", bus.bufferLength); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            n_cmp++; if (bus.dataRead !== rv[i]) begin n_bad++; $display("FAIL rw_drain[%0d]: got %h want %h", i, bus.dataRead, rv[i]); end
        end
        n_cmp++; if (bus.bufferLength !== 32'd0) begin n_bad++; $display("FAIL rw_drain_len: got %0d want 0", bus.bufferLength); end
        cyc(1'b1, 8'h77, 1'b1);
        n_cmp++; if (bus.dataReadAck !== 1'b0) begin n_bad++; $display("FAIL rw_empty_ack: got %b want 0", bus.dataReadAck); end
        n_cmp++; if (bus.bufferLength !== 32'd1) begin n_bad++; $display("FAIL rw_empty_len: got %0d want 1", bus.bufferLength); end
        n_cmp++; if (bus.dataRead !== 8'hAA) begin n_bad++; $display("FAIL rw_empty_hold: got %h want aa", bus.dataRead); end
        cyc(1'b0, 8'h00, 1'b1);
        n_cmp++; if (bus.dataReadAck !== 1'b1 || bus.dataRead !== 8'h77) begin n_bad++; $display("FAIL rw_empty_follow: got ack=%b data=%h want ack=1 data=77", bus.dataReadAck, bus.dataRead); end
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 8'h21, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h23, 1'b0);
        n_cmp++; if (bus.bufferLength !== 32'd3) begin n_bad++; $display("FAIL rmid_pre_len: got %0d want 3", bus.bufferLength); end
        reset = 1'b0;
        cyc(1'b1, 8'h99, 1'b1);
        n_cmp++; if (bus.bufferLength !== 32'd0) begin n_bad++; $display("FAIL rmid_len: got %0d want 0", bus.bufferLength); end
        n_cmp++; if (bus.dataReadAck !== 1'b0) begin n_bad++; $display("FAIL rmid_ack: got %b want 0", bus.dataReadAck); end
        n_cmp++; if (bus.debug !== 32'd0 || bus.debug2 !== 32'd0) begin n_bad++; $display("FAIL rmid_ptrs: got head=%0d tail=%0d want 0/0", bus.debug, bus.debug2); end
        reset = 1'b1;
        cyc(1'b1, 8'h5C, 1'b0);
        n_cmp++; if (bus.bufferLength !== 32'd1) begin n_bad++; $display("FAIL rmid_wr_len: got %0d want 1", bus.bufferLength); end
        cyc(1'b0, 8'h00, 1'b1);
        n_cmp++; if (bus.dataReadAck !== 1'b1 || bus.dataRead !== 8'h5C) begin n_bad++; $display("FAIL rmid_rd: got ack=%b data=%h want ack=1 data=5c", bus.dataReadAck, bus.dataRead); end
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bus.writeEnable = 1'b0;
        bus.data        = 8'h00;
        bus.readEnable  = 1'b0;
        test_reset();
        test_fill_drain();
        test_full_wrap();
        test_empty_read();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
